// File: rtl/comb3_sched.sv
// comb3_sched: two-requester round-robin front end for a shared comb3 datapath.
// Each operation runs IDLE -> EXEC -> RESP and holds its result until it is accepted.
module comb3_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  input  logic [WIDTH-1:0] dp_o,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   prio;
  logic   win;
  logic   any_req;

  // prio names the requester favoured when both ask
  assign any_req = req0 | req1;
  assign win     = (req0 & req1) ? prio : req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      dp_a      <= '0;
      dp_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state  <= EXEC;
            busy   <= 1'b1;
            rsp_id <= win;
            gnt0   <= ~win;
            gnt1   <= win;
            dp_a   <= win ? a1 : a0;
            dp_b   <= win ? b1 : b0;
            prio   <= ~win;
          end
        end
        EXEC: begin
          rsp_data  <= dp_o;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comb3_sched.sv
// tb_comb3_sched: randomized checks of comb3_sched against an
// operation-level round-robin model with a comb3 stub (O = A ^ B).
module tb_comb3_sched;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] a0 = '0;
  logic [W-1:0] b0 = '0;
  logic [W-1:0] a1 = '0;
  logic [W-1:0] b1 = '0;
  logic         rsp_ready = 1'b0;
  logic         gnt0, gnt1, rsp_valid, rsp_id, busy;
  logic [W-1:0] dp_a, dp_b, dp_o, rsp_data;

  int passed = 0;
  int total  = 0;
  bit prio_m = 1'b0;

  comb3_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .dp_a(dp_a), .dp_b(dp_b), .dp_o(dp_o),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  assign dp_o = dp_a ^ dp_b;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req0 = 1'b0;
    req1 = 1'b0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    prio_m = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    total++;
    if ({gnt0, gnt1} !== 2'b00)
      $display("FAIL reset_gnt: got %b want 00", {gnt0, gnt1});
    else passed++;
    total++;
    if ({rsp_valid, busy, rsp_id} !== 3'b000)
      $display("FAIL reset_ctl: got %b want 000", {rsp_valid, busy, rsp_id});
    else passed++;
    total++;
    if ({dp_a, dp_b, rsp_data} !== '0)
      $display("FAIL reset_data: got %h want 000", {dp_a, dp_b, rsp_data});
    else passed++;
    tick();
    tick();
    rst_n = 1'b1;
    prio_m = 1'b0;
    tick();
  endtask

  task automatic test_single;
    do_reset();
    req0 = 1'b1;
    a0 = 4'b1111;
    b0 = 4'b0010;
    rsp_ready = 1'b1;
    tick();
    req0 = 1'b0;
    total++;
    if ({gnt0, gnt1, rsp_id, busy, rsp_valid} !== 5'b10010)
      $display("FAIL single_grant: got %b want 10010",
               {gnt0, gnt1, rsp_id, busy, rsp_valid});
    else passed++;
    total++;
    if ({dp_a, dp_b} !== 8'b1111_0010)
      $display("FAIL single_operands: got %b want 11110010", {dp_a, dp_b});
    else passed++;
    tick();
    total++;
    if ({gnt0, rsp_valid, rsp_id, rsp_data} !== 7'b0_1_0_1101)
      $display("FAIL single_rsp: got %b want 0101101",
               {gnt0, rsp_valid, rsp_id, rsp_data});
    else passed++;
    tick();
    total++;
    if ({rsp_valid, busy} !== 2'b00)
      $display("FAIL single_done: got %b want 00", {rsp_valid, busy});
    else passed++;
    prio_m = 1'b1;
  endtask

  // One operation with optional backpressure; noisy drives both
  // requests and fresh operands while the response is stalled.
  task automatic run_op(input bit r0, input bit r1,
                        input logic [W-1:0] x0, input logic [W-1:0] y0,
                        input logic [W-1:0] x1, input logic [W-1:0] y1,
                        input int stall, input bit noisy);
    bit           w;
    logic [W-1:0] ea, eb, sd;
    bit           sid;
    w = (r0 && r1) ? prio_m : r1;
    prio_m = ~w;
    ea = w ? x1 : x0;
    eb = w ? y1 : y0;
    req0 = r0; req1 = r1;
    a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    rsp_ready = (stall == 0);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    total++;
    if ({gnt0, gnt1, rsp_id} !== {~w, w, w})
      $display("FAIL op_grant: got %b want %b", {gnt0, gnt1, rsp_id}, {~w, w, w});
    else passed++;
    total++;
    if ({dp_a, dp_b} !== {ea, eb})
      $display("FAIL op_operands: got %h want %h", {dp_a, dp_b}, {ea, eb});
    else passed++;
    tick();
    total++;
    if ({gnt0, gnt1, rsp_valid, rsp_id, rsp_data} !== {2'b00, 1'b1, w, ea ^ eb})
      $display("FAIL op_rsp: got %b want %b",
               {gnt0, gnt1, rsp_valid, rsp_id, rsp_data},
               {2'b00, 1'b1, w, ea ^ eb});
    else passed++;
    sd = ea ^ eb;
    sid = w;
    for (int i = 0; i < stall; i++) begin
      if (noisy) begin
        req0 = 1'b1; req1 = 1'b1;
        a0 = W'($urandom); b0 = W'($urandom);
        a1 = W'($urandom); b1 = W'($urandom);
      end
      tick();
      total++;
      if ({rsp_valid, rsp_id, rsp_data, gnt0, gnt1, busy, dp_a, dp_b}
          !== {1'b1, sid, sd, 2'b00, 1'b1, ea, eb})
        $display("FAIL stall_hold: got %b want %b",
                 {rsp_valid, rsp_id, rsp_data, gnt0, gnt1, busy, dp_a, dp_b},
                 {1'b1, sid, sd, 2'b00, 1'b1, ea, eb});
      else passed++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    rsp_ready = 1'b1;
    tick();
    total++;
    if ({rsp_valid, busy, gnt0, gnt1} !== 4'b0000)
      $display("FAIL op_release: got %b want 0000", {rsp_valid, busy, gnt0, gnt1});
    else passed++;
  endtask

  task automatic test_contention;
    int cyc, last, budget;
    bit who;
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    a0 = 4'b1111; b0 = 4'b0010;
    a1 = 4'b0101; b1 = 4'b0011;
    rsp_ready = 1'b1;
    cyc = 0;
    last = 0;
    for (int n = 0; n < 5; n++) begin
      budget = 0;
      do begin
        tick();
        cyc++;
        budget++;
      end while (!(gnt0 || gnt1) && budget < 6);
      who = (n % 2) == 1;
      total++;
      if ({gnt0, gnt1} !== {~who, who})
        $display("FAIL contend_order%0d: got %b want %b", n, {gnt0, gnt1}, {~who, who});
      else passed++;
      if (n > 0) begin
        total++;
        if (cyc - last != 3)
          $display("FAIL contend_gap%0d: got %0d want 3", n, cyc - last);
        else passed++;
      end
      last = cyc;
      tick();
      cyc++;
      total++;
      if ({rsp_valid, rsp_data} !== {1'b1, who ? 4'b0110 : 4'b1101})
        $display("FAIL contend_data%0d: got %b want %b", n,
                 {rsp_valid, rsp_data}, {1'b1, who ? 4'b0110 : 4'b1101});
      else passed++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    prio_m = 1'b1;
  endtask

  task automatic test_backpressure;
    do_reset();
    run_op(1'b1, 1'b0, 4'h9, 4'h3, 4'h0, 4'h0, 5, 1'b1);
    run_op(1'b1, 1'b1, 4'h1, 4'h2, 4'h7, 4'hc, 5, 1'b1);
  endtask

  task automatic test_reset_midop;
    do_reset();
    req0 = 1'b1;
    a0 = 4'hb; b0 = 4'h4;
    rsp_ready = 1'b1;
    tick();
    req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({gnt0, gnt1, rsp_valid, busy, rsp_id, dp_a, dp_b, rsp_data} !== '0)
      $display("FAIL midop_async: got %h want 0",
               {gnt0, gnt1, rsp_valid, busy, rsp_id, dp_a, dp_b, rsp_data});
    else passed++;
    #1;
    rst_n = 1'b1;
    prio_m = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if ({rsp_valid, busy, gnt0, gnt1} !== 4'b0000)
        $display("FAIL midop_abort%0d: got %b want 0000", i,
                 {rsp_valid, busy, gnt0, gnt1});
      else passed++;
    end
    run_op(1'b1, 1'b1, 4'h6, 4'h5, 4'h3, 4'h8, 0, 1'b0);
  endtask

  task automatic test_idle;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({busy, gnt0, gnt1, rsp_valid} !== 4'b0000)
        $display("FAIL idle_hold%0d: got %b want 0000", i,
                 {busy, gnt0, gnt1, rsp_valid});
      else passed++;
    end
  endtask

  task automatic test_random;
    int r;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(1, 3);
      run_op(r[0], r[1],
             W'($urandom), W'($urandom), W'($urandom), W'($urandom),
             $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_midop();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
